// File: rtl/shift_operand_stage.sv
// Operand stage feeding the barrel shifter: captures rotated-immediate or register
// operands and waits for Rs on register-specified shifts. Optional flush: SHIFT_STAGE_FLUSH_EN.
module shift_operand_stage (
  input  logic        clk,
  input  logic        rst,
`ifdef SHIFT_STAGE_FLUSH_EN
  input  logic        flush,
`endif
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        imm_form,
  input  logic [7:0]  imm8,
  input  logic [3:0]  rot,
  input  logic        shift_by_reg,
  input  logic [4:0]  shift_imm,
  input  logic [1:0]  shift_op,
  input  logic [31:0] rm_data,
  input  logic [7:0]  rs_data,
  input  logic        rs_valid,
  input  logic        c_flag,
  output logic [31:0] op1,
  output logic [7:0]  shift_amount,
  output logic [2:0]  shift_type,
  output logic        c_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  state_dbg
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; valid never depends on ready, and outputs hold while valid && !ready.

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    WAIT_RS = 2'd1,
    FULL    = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   flush_i;
  logic   accept;
  logic   load_rs;

`ifdef SHIFT_STAGE_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    load_rs   = 1'b0;
    case (state)
      EMPTY:   in_ready = 1'b1;
      WAIT_RS: begin
        if (rs_valid) begin
          load_rs   = 1'b1;
          state_nxt = FULL;
        end
      end
      FULL: begin
        in_ready = out_ready;
        if (out_ready) state_nxt = EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
    if (rst || flush_i) in_ready = 1'b0;
    accept = in_valid && in_ready;
    if (accept) state_nxt = (!imm_form && shift_by_reg) ? WAIT_RS : FULL;
    // Flush beats both a pending Rs arrival and a new acceptance.
    if (flush_i) begin
      state_nxt = EMPTY;
      load_rs   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op1          <= 32'h0;
      shift_amount <= 8'h0;
      shift_type   <= 3'b000;
      c_out        <= 1'b0;
    end else if (accept) begin
      if (imm_form) begin
        op1          <= {24'h0, imm8};
        shift_amount <= {3'b000, rot, 1'b0};
        shift_type   <= 3'b011;
        c_out        <= c_flag;
      end else begin
        op1        <= rm_data;
        shift_type <= {~shift_by_reg, shift_op};
        // Register-specified shifts take amount and carry when Rs arrives.
        if (!shift_by_reg) begin
          shift_amount <= {3'b000, shift_imm};
          c_out        <= c_flag;
        end
      end
    end else if (load_rs) begin
      shift_amount <= rs_data;
      c_out        <= c_flag;
    end
  end

  assign out_valid = (state == FULL);
  assign state_dbg = state;

endmodule

// File: tb/tb_shift_operand_stage.sv
// Self-checking bench for shift_operand_stage: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_shift_operand_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        imm_form;
  logic [7:0]  imm8;
  logic [3:0]  rot;
  logic        shift_by_reg;
  logic [4:0]  shift_imm;
  logic [1:0]  shift_op;
  logic [31:0] rm_data;
  logic [7:0]  rs_data;
  logic        rs_valid;
  logic        c_flag;
  logic [31:0] op1;
  logic [7:0]  shift_amount;
  logic [2:0]  shift_type;
  logic        c_out;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  state_dbg;
`ifdef SHIFT_STAGE_FLUSH_EN
  logic        flush;
`endif

  int checks;
  int failures;

  logic [43:0] exp_q[$];

  shift_operand_stage dut (
    .clk(clk), .rst(rst),
`ifdef SHIFT_STAGE_FLUSH_EN
    .flush(flush),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .imm_form(imm_form), .imm8(imm8),
    .rot(rot), .shift_by_reg(shift_by_reg), .shift_imm(shift_imm), .shift_op(shift_op),
    .rm_data(rm_data), .rs_data(rs_data), .rs_valid(rs_valid), .c_flag(c_flag),
    .op1(op1), .shift_amount(shift_amount), .shift_type(shift_type), .c_out(c_out),
    .out_valid(out_valid), .out_ready(out_ready), .state_dbg(state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic drive_idle();
    in_valid = 1'b0; imm_form = 1'b0; imm8 = 8'h0; rot = 4'h0; shift_by_reg = 1'b0;
    shift_imm = 5'h0; shift_op = 2'b00; rm_data = 32'h0; rs_data = 8'h0;
    rs_valid = 1'b0; c_flag = 1'b0; out_ready = 1'b1;
`ifdef SHIFT_STAGE_FLUSH_EN
    flush = 1'b0;
`endif
  endtask

  task automatic drive_imm(input logic [7:0] v, input logic [3:0] r, input logic c);
    in_valid = 1'b1; imm_form = 1'b1; imm8 = v; rot = r; c_flag = c; shift_by_reg = 1'b0;
  endtask

  task automatic drive_reg(input logic [31:0] rm, input logic sbr, input logic [1:0] op,
                           input logic [4:0] si, input logic c);
    in_valid = 1'b1; imm_form = 1'b0; rm_data = rm; shift_by_reg = sbr; shift_op = op;
    shift_imm = si; c_flag = c;
  endtask

  task automatic test_reset();
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    drive_imm(8'hA5, 4'h3, 1'b1);
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if ({op1, shift_amount, shift_type, c_out} !== 44'h0) begin failures++; $display("FAIL reset_data got=%h/%h/%b/%b exp=0", op1, shift_amount, shift_type, c_out); end
    rst = 1'b0;
    drive_idle();
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_imm_operand();
    @(negedge clk);
    drive_idle();
    out_ready = 1'b0;
    drive_imm(8'hFF, 4'h4, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; c_flag = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL imm_valid got=%b exp=1", out_valid); end
    checks++; if (op1 !== 32'h000000FF) begin failures++; $display("FAIL imm_op1 got=%h exp=000000ff", op1); end
    checks++; if (shift_amount !== 8'h08) begin failures++; $display("FAIL imm_amount got=%h exp=08", shift_amount); end
    checks++; if (shift_type !== 3'b011) begin failures++; $display("FAIL imm_type got=%b exp=011", shift_type); end
    checks++; if (c_out !== 1'b1) begin failures++; $display("FAIL imm_c_out got=%b exp=1", c_out); end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL imm_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_reg_imm_shift();
    @(negedge clk);
    drive_idle();
    drive_reg(32'h80000000, 1'b0, 2'b01, 5'd0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; c_flag = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL regimm_valid got=%b exp=1", out_valid); end
    checks++; if ({op1, shift_amount, shift_type, c_out} !== {32'h80000000, 8'h00, 3'b101, 1'b0})
      begin failures++; $display("FAIL regimm_data got=%h/%h/%b/%b exp=80000000/00/101/0", op1, shift_amount, shift_type, c_out); end
    @(posedge clk);
  endtask

  task automatic test_reg_shift_wait();
    @(negedge clk);
    drive_idle();
    drive_reg(32'h12345678, 1'b1, 2'b11, 5'd7, 1'b0);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_imm(8'h3C, 4'h1, 1'b0);
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL wait_in_ready cycle=%0d got=%b exp=0", i, in_ready); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL wait_out_valid cycle=%0d got=%b exp=0", i, out_valid); end
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0; rs_valid = 1'b1; rs_data = 8'h28; c_flag = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL wait_rs_cycle got ready=%b valid=%b exp=0/0", in_ready, out_valid); end
    @(posedge clk);
    @(negedge clk);
    rs_valid = 1'b0; c_flag = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rs_out_valid got=%b exp=1", out_valid); end
    checks++; if ({op1, shift_amount, shift_type, c_out} !== {32'h12345678, 8'h28, 3'b011, 1'b1})
      begin failures++; $display("FAIL rs_data got=%h/%h/%b/%b exp=12345678/28/011/1", op1, shift_amount, shift_type, c_out); end
    @(posedge clk);
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_idle();
      v = 8'h10 + 8'(i);
      drive_imm(v, 4'(i), 1'(i));
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready i=%0d got=%b exp=1", i, in_ready); end
      if (i > 0) begin
        checks++; if (out_valid !== 1'b1 || op1 !== 32'(v - 8'h1))
          begin failures++; $display("FAIL b2b_out i=%0d got=%b/%h exp=1/%h", i, out_valid, op1, v - 8'h1); end
      end
      @(posedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      out_ready = (i == 2);
      if (i < 2) drive_imm(8'h55, 4'h9, 1'b0);
      else in_valid = 1'b0;
      #1;
      checks++; if ({out_valid, op1, shift_amount, shift_type, c_out} !== {1'b1, 32'h13, 8'h06, 3'b011, 1'b1})
        begin failures++; $display("FAIL stall_hold i=%0d got=%b/%h/%h/%b/%b exp=1/13/06/011/1", i, out_valid, op1, shift_amount, shift_type, c_out); end
      if (i < 2) begin
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_ready i=%0d got=%b exp=0", i, in_ready); end
      end
      @(posedge clk);
    end
    @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk);
    drive_idle();
    drive_reg(32'hDEADBEEF, 1'b1, 2'b10, 5'd3, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if ({out_valid, op1, shift_amount, shift_type, c_out} !== 45'h0)
      begin failures++; $display("FAIL rstwait_outputs got=%b/%h/%h/%b/%b exp=0", out_valid, op1, shift_amount, shift_type, c_out); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rstwait_ready got=%b exp=1", in_ready); end
    rs_valid = 1'b1; rs_data = 8'h33; c_flag = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rs_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || shift_amount !== 8'h00 || c_out !== 1'b0)
      begin failures++; $display("FAIL rstwait_rs_ignored got=%b/%h/%b exp=0/00/0", out_valid, shift_amount, c_out); end
  endtask

`ifdef SHIFT_STAGE_FLUSH_EN
  task automatic test_flush();
    @(negedge clk);
    drive_idle();
    out_ready = 1'b0;
    drive_imm(8'h77, 4'h2, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive_imm(8'h99, 4'h5, 1'b0);
    out_ready = 1'b1;
    flush = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%b exp=0", in_ready); end
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
    checks++; if (op1 !== 32'h77 || shift_amount !== 8'h04) begin failures++; $display("FAIL flush_data got=%h/%h exp=77/04", op1, shift_amount); end
    @(posedge clk);
  endtask
`endif

  // Randomized run against a transaction model: at most one held result plus
  // at most one operand still waiting for its Rs value.
  task automatic test_random();
    logic        pending;
    logic [31:0] p_op1;
    logic [2:0]  p_type;
    logic        exp_ready;
    logic        do_flush;
    exp_q.delete();
    pending = 1'b0;
    p_op1 = 32'h0;
    p_type = 3'b000;
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      rst          = ($urandom_range(0, 63) == 0);
      in_valid     = 1'($urandom_range(0, 1));
      out_ready    = ($urandom_range(0, 3) != 0);
      rs_valid     = ($urandom_range(0, 2) == 0);
      imm_form     = 1'($urandom_range(0, 1));
      shift_by_reg = 1'($urandom_range(0, 1));
      imm8         = 8'($urandom);
      rot          = 4'($urandom);
      shift_imm    = 5'($urandom);
      shift_op     = 2'($urandom);
      rm_data      = $urandom;
      rs_data      = 8'($urandom);
      c_flag       = 1'($urandom_range(0, 1));
      do_flush     = 1'b0;
`ifdef SHIFT_STAGE_FLUSH_EN
      do_flush     = ($urandom_range(0, 31) == 0);
      flush        = do_flush;
`endif
      #1;
      exp_ready = !rst && !do_flush && !pending && (exp_q.size() == 0 || out_ready);
      checks++; if (in_ready !== exp_ready) begin failures++; $display("FAIL rand_in_ready n=%0d got=%b exp=%b", n, in_ready, exp_ready); end
      checks++; if (out_valid !== (exp_q.size() != 0)) begin failures++; $display("FAIL rand_out_valid n=%0d got=%b exp=%b", n, out_valid, exp_q.size() != 0); end
      if (exp_q.size() != 0) begin
        checks++; if ({op1, shift_amount, shift_type, c_out} !== exp_q[0])
          begin failures++; $display("FAIL rand_data n=%0d got=%h exp=%h", n, {op1, shift_amount, shift_type, c_out}, exp_q[0]); end
      end
      @(posedge clk);
      if (rst || do_flush) begin
        exp_q.delete();
        pending = 1'b0;
      end else begin
        if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
        if (pending && rs_valid) begin
          exp_q.push_back({p_op1, rs_data, p_type, c_flag});
          pending = 1'b0;
        end
        if (in_valid && exp_ready) begin
          if (imm_form)
            exp_q.push_back({32'(imm8), 8'(rot) * 8'd2, 3'd3, c_flag});
          else if (!shift_by_reg)
            exp_q.push_back({rm_data, 8'(shift_imm), 3'd4 + 3'(shift_op), c_flag});
          else begin
            pending = 1'b1;
            p_op1   = rm_data;
            p_type  = 3'(shift_op);
          end
        end
      end
    end
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    drive_idle();
    rst = 1'b1;
    test_reset();
    test_imm_operand();
    test_reg_imm_shift();
    test_reg_shift_wait();
    test_back_to_back();
    test_reset_in_wait();
`ifdef SHIFT_STAGE_FLUSH_EN
    test_flush();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_operand_stage.md
SHIFT_OPERAND_STAGE -- requirements
Module: shift_operand_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk, rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 in_valid / in_ready  input / output  1 / 1  upstream handshake; a transfer occurs when both are high at a rising edge.
REQ-005 imm_form  input  1  1 = 8-bit rotated-immediate operand, 0 = register operand.
REQ-006 imm8 / rot  input  8 / 4  immediate value and rotate field.
REQ-007 shift_by_reg  input  1  register-specified shift amount (Rs); ignored when imm_form=1.
REQ-008 shift_imm / shift_op  input  5 / 2  immediate shift amount and shift type (00 LSL, 01 LSR, 10 ASR, 11 ROR).
REQ-009 rm_data  input  32  Rm operand value.
REQ-010 rs_data / rs_valid  input  8 / 1  Rs[7:0] from the second register-read port, arriving one or more cycles after acceptance.
REQ-011 c_flag  input  1  current CPSR C flag.
REQ-012 op1 / shift_amount / shift_type / c_out  output  32 / 8 / 3 / 1  registered operands for the barrel shifter.
REQ-013 out_valid / out_ready  output / input  1 / 1  downstream handshake.

Function
REQ-014 The FSM SHALL have the states EMPTY, WAIT_RS and FULL; out_valid SHALL be 1 only in FULL.
REQ-015 in_ready SHALL be 1 in EMPTY, or in FULL while out_ready=1; it SHALL be 0 in WAIT_RS.
REQ-016 Accepting an imm_form=1 operand SHALL load op1={24'h0,imm8}, shift_amount={3'b000,rot,1'b0}, shift_type=3'b011 and c_out=c_flag, then enter FULL next cycle (latency 1).
REQ-017 Accepting imm_form=0 with shift_by_reg=0 SHALL load op1=rm_data, shift_amount={3'b000,shift_imm}, shift_type={1'b1,shift_op} and c_out=c_flag, then enter FULL (latency 1).
REQ-018 Accepting imm_form=0 with shift_by_reg=1 SHALL load op1=rm_data and shift_type={1'b0,shift_op}, then enter WAIT_RS.
REQ-019 In WAIT_RS, a cycle with rs_valid=1 SHALL load shift_amount=rs_data and c_out=c_flag and enter FULL; with rs_valid=0 the block SHALL remain in WAIT_RS indefinitely.
REQ-020 The minimum latency of a register-shift operand SHALL be 2 cycles.
REQ-021 In FULL, out_ready=1 with in_valid=0 SHALL enter EMPTY; out_ready=1 with in_valid=1 SHALL accept the new operand in the same cycle (back-to-back, no bubble).
REQ-022 In FULL with out_ready=0, all outputs SHALL hold stable.
REQ-023 shift_amount values >= 32 from rs_data SHALL pass through unmodified.
REQ-024 rs_valid SHALL be ignored outside WAIT_RS.

Reset
REQ-025 rst=1 at a rising edge SHALL force EMPTY, out_valid=0, op1=0, shift_amount=0, shift_type=0 and c_out=0, overriding any handshake in that cycle.
REQ-026 While rst=1, in_ready SHALL be 0; reset asserted in WAIT_RS or FULL SHALL discard the pending operand.

Configuration
REQ-027 Macro SHIFT_STAGE_FLUSH_EN: when defined, the block SHALL add an input port flush (1 bit); flush=1 at a rising edge SHALL force EMPTY and out_valid=0 without changing the data registers, and in_ready SHALL be 0 while flush=1.
REQ-028 flush SHALL have priority over acceptance and over rs_valid, and rst SHALL have priority over flush.
REQ-029 When SHIFT_STAGE_FLUSH_EN is undefined, the flush port SHALL be absent and the FSM SHALL behave as specified without a flush path.

Verification
REQ-030 imm_form=1, imm8=8'hFF, rot=4'h4, c_flag=1 -> next cycle out_valid=1, op1=32'h000000FF, shift_amount=8'h08, shift_type=3'b011, c_out=1.
REQ-031 Register operand, shift_op=01, shift_imm=0, rm_data=32'h80000000, shift_by_reg=0 -> shift_amount=8'h00, shift_type=3'b101, latency 1.
REQ-032 shift_by_reg=1, rm_data=32'h12345678, shift_op=11, rs_valid delayed 3 cycles with rs_data=8'h28 -> out_valid rises 1 cycle after rs_valid, shift_amount=8'h28, shift_type=3'b011, and in_ready=0 throughout the wait.
REQ-033 Four back-to-back immediate operands with out_ready=1 -> 4 outputs on 4 consecutive cycles; with out_ready held 0 for 2 cycles -> outputs stable and in_ready=0.
REQ-034 rst asserted while in WAIT_RS -> EMPTY next cycle, all outputs 0, and a later rs_valid pulse is ignored.
REQ-035 With SHIFT_STAGE_FLUSH_EN defined: flush and in_valid asserted together in FULL -> EMPTY next cycle, out_valid=0, and the input is not accepted.
